// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - tx_state_t     : transmitter FSM states
//   - baud_div()     : integer clock divider with round-to-nearest
//   - UART_DATA_BITS : data bits per frame
//   - UART_IDLE      : line level when no frame is in flight
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Cycles per bit, rounded to the nearest integer so the bit-rate error is
    // at most half a clock per bit.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. rd_data always presents the head entry, so a
// pop consumes the value visible in the same cycle.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   wr_en, wr_data  : push request and data
//   rd_en           : pop request (ignored when empty)
//   rd_data         : head entry
//   full, empty     : occupancy flags
//   level           : registered occupancy, 0..DEPTH
//   overflow        : high in the cycle a push is dropped
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LEVEL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full  = (level == LEVEL_W'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop      = rd_en && !empty;
    assign push     = wr_en && (!full || pop);
    assign overflow = wr_en && !push;

    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and level define
    // which entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// FIFO-buffered UART transmitter: 8 data bits LSB first, optional parity,
// one stop bit, internal baud divider. Frames queued back to back leave the
// line with no idle gap between stop and the next start bit.
// Ports:
//   clk, reset      : system clock, asynchronous active-low reset
//   wr_en, wr_data  : byte write strobe and data
//   full, empty     : FIFO flags
//   level           : FIFO occupancy
//   overflow        : pulse when a write is dropped
//   txd             : registered serial output, idle high
//   busy            : high from start bit through end of stop bit
//   done            : pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH      = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   txd,
    output logic                   busy,
    output logic                   done
);

    localparam int              DIV    = baud_div(CLK_HZ, BAUD);
    localparam int              CNT_W  = $clog2(DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);
    localparam int              IDX_W  = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);
    localparam logic            PAR_EN  = (PARITY_EN != 0);
    localparam logic            PAR_ODD = (PARITY_ODD != 0);

    tx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]          idx_q;
    logic                      par_q;
    logic                      txd_q, txd_d;
    logic                      busy_q;
    logic                      bit_end;
    logic                      pop;
    logic [7:0]                fifo_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (fifo_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    assign bit_end = (cnt_q == '0);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end && idx_q == LAST_IDX) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                // Chaining straight into START keeps queued frames gap-free.
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        shift_d = shift_q;
        if (pop) begin
            shift_d = fifo_data;
        end else if (state_q == DATA && bit_end) begin
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        end

        // txd is computed from the next state so the pin is a flop output.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_q;
            default: txd_d = UART_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= UART_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= (state_d != IDLE);
            if (pop) begin
                cnt_q <= RELOAD;
                idx_q <= '0;
                par_q <= (^fifo_data) ^ PAR_ODD;
            end else if (state_q != IDLE) begin
                cnt_q <= bit_end ? RELOAD : cnt_q - 1'b1;
                if (state_q == DATA && bit_end) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo at CLK_HZ=1 MHz, BAUD=100 kHz (DIV=10).
// dut_a: DEPTH=4, no parity.  dut_pe / dut_po: even / odd parity, DEPTH=16.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge into per-cycle logs indexed by the cycle counter.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int LOG_N  = 2048;

    typedef struct {
        int   off;
        logic txd;
        logic busy;
        logic done;
        logic empty;
    } pt_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       full;
        logic [2:0] level;
        logic       ovf;
    } wr_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en_a, wr_en_p;
    logic [7:0] wr_data_a, wr_data_p;

    logic       full_a, empty_a, ovf_a, txd_a, busy_a, done_a;
    logic [2:0] level_a;
    logic       full_pe, empty_pe, ovf_pe, txd_pe, busy_pe, done_pe;
    logic [4:0] level_pe;
    logic       full_po, empty_po, ovf_po, txd_po, busy_po, done_po;
    logic [4:0] level_po;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .full(full_a), .empty(empty_a), .level(level_a), .overflow(ovf_a),
        .txd(txd_a), .busy(busy_a), .done(done_a)
    );

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk(clk), .reset(reset), .wr_en(wr_en_p), .wr_data(wr_data_p),
        .full(full_pe), .empty(empty_pe), .level(level_pe), .overflow(ovf_pe),
        .txd(txd_pe), .busy(busy_pe), .done(done_pe)
    );

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk(clk), .reset(reset), .wr_en(wr_en_p), .wr_data(wr_data_p),
        .full(full_po), .empty(empty_po), .level(level_po), .overflow(ovf_po),
        .txd(txd_po), .busy(busy_po), .done(done_po)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic txd_l [LOG_N];
    logic busy_l [LOG_N];
    logic done_l [LOG_N];
    logic empty_l [LOG_N];
    logic ovf_l [LOG_N];
    logic txd_pe_l [LOG_N];
    logic txd_po_l [LOG_N];
    logic done_pe_l [LOG_N];
    logic done_po_l [LOG_N];
    int   done_q[$];

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            txd_l[cyc]     = txd_a;
            busy_l[cyc]    = busy_a;
            done_l[cyc]    = done_a;
            empty_l[cyc]   = empty_a;
            ovf_l[cyc]     = ovf_a;
            txd_pe_l[cyc]  = txd_pe;
            txd_po_l[cyc]  = txd_po;
            done_pe_l[cyc] = done_pe;
            done_po_l[cyc] = done_po;
        end
        if (done_a) done_q.push_back(cyc);
    end

    // Receiver model for dut_a: frame starts on the first low sample, each
    // bit is sampled in its middle, the byte is kept only if the stop bit is 1.
    logic [7:0] rx_bytes[$];
    logic [7:0] rx_sh;
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (txd_a === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % 10 == 5 && rx_cnt >= 15 && rx_cnt <= 85) begin
                rx_sh[(rx_cnt - 15) / 10] = txd_a;
            end
            if (rx_cnt == 95) begin
                if (txd_a === 1'b1) rx_bytes.push_back(rx_sh);
                rx_active = 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_a(input logic [7:0] b);
        wr_en_a   = 1'b1;
        wr_data_a = b;
        @(posedge clk);
        #1;
        wr_en_a   = 1'b0;
    endtask

    pt_vec_t    t1_tab [13];
    wr_vec_t    ovf_tab [6];
    logic [9:0] frame55;
    logic [7:0] burst [3];
    int t1, t2, t3, t4, t5, r, n;

    initial begin
        t1_tab = '{
            '{0,   1'b1, 1'b0, 1'b0, 1'b1},
            '{1,   1'b1, 1'b0, 1'b0, 1'b0},
            '{2,   1'b0, 1'b1, 1'b0, 1'b1},
            '{11,  1'b0, 1'b1, 1'b0, 1'b1},
            '{12,  1'b1, 1'b1, 1'b0, 1'b1},
            '{21,  1'b1, 1'b1, 1'b0, 1'b1},
            '{22,  1'b0, 1'b1, 1'b0, 1'b1},
            '{91,  1'b0, 1'b1, 1'b0, 1'b1},
            '{92,  1'b1, 1'b1, 1'b0, 1'b1},
            '{100, 1'b1, 1'b1, 1'b0, 1'b1},
            '{101, 1'b1, 1'b1, 1'b1, 1'b1},
            '{102, 1'b1, 1'b0, 1'b0, 1'b1},
            '{105, 1'b1, 1'b0, 1'b0, 1'b1}
        };
        ovf_tab = '{
            '{8'h11, 1'b0, 3'd0, 1'b0},
            '{8'h22, 1'b0, 3'd1, 1'b0},
            '{8'h33, 1'b0, 3'd2, 1'b0},
            '{8'h44, 1'b0, 3'd3, 1'b0},
            '{8'h55, 1'b1, 3'd4, 1'b1},
            '{8'h66, 1'b1, 3'd4, 1'b1}
        };
        frame55 = {1'b1, 8'h55, 1'b0};
        burst   = '{8'hA3, 8'h00, 8'hFF};

        reset = 1'b0; wr_en_a = 1'b0; wr_data_a = 8'h00; wr_en_p = 1'b0; wr_data_p = 8'h00;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", txd_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_level", level_a, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        wait_until(cyc + 3);

        // ---- single byte 0x55 ----
        t1 = cyc;
        write_a(8'h55);
        wait_until(t1 + 110);
        foreach (t1_tab[i]) begin
            check($sformatf("t1_txd@%0d", t1_tab[i].off), txd_l[t1 + t1_tab[i].off], t1_tab[i].txd);
            check($sformatf("t1_busy@%0d", t1_tab[i].off), busy_l[t1 + t1_tab[i].off], t1_tab[i].busy);
            check($sformatf("t1_done@%0d", t1_tab[i].off), done_l[t1 + t1_tab[i].off], t1_tab[i].done);
            check($sformatf("t1_empty@%0d", t1_tab[i].off), empty_l[t1 + t1_tab[i].off], t1_tab[i].empty);
        end
        for (int i = 0; i < 10; i++) begin
            n = 0;
            for (int j = 0; j < 10; j++) if (txd_l[t1 + 2 + 10 * i + j] !== frame55[i]) n++;
            check($sformatf("t1_bit%0d_held", i), n, 0);
        end
        n = 0;
        for (int c = t1; c < t1 + 110; c++) if (done_l[c] === 1'b1) n++;
        check("t1_done_count", n, 1);
        check("t1_rx_count", rx_bytes.size(), 1);
        if (rx_bytes.size() > 0) check("t1_rx_byte", rx_bytes[0], 8'h55);

        // ---- three back-to-back frames ----
        rx_bytes.delete();
        done_q.delete();
        t2 = cyc;
        for (int i = 0; i < 3; i++) begin
            wr_en_a = 1'b1; wr_data_a = burst[i];
            @(posedge clk); #1;
        end
        wr_en_a = 1'b0;
        wait_until(t2 + 310);
        check("t2_done_count", done_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < done_q.size()) check($sformatf("t2_done%0d_cycle", i), done_q[i] - t2, 101 + 100 * i);
        end
        check("t2_stop1_end", txd_l[t2 + 101], 1);
        check("t2_start2_nogap", txd_l[t2 + 102], 0);
        check("t2_start3_nogap", txd_l[t2 + 202], 0);
        n = 0;
        for (int c = t2 + 2; c <= t2 + 301; c++) if (busy_l[c] !== 1'b1) n++;
        check("t2_busy_gaps", n, 0);
        check("t2_busy_fall", busy_l[t2 + 302], 0);
        check("t2_rx_count", rx_bytes.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_bytes.size()) check($sformatf("t2_rx%0d", i), rx_bytes[i], burst[i]);
        end

        // ---- parity: 0x07 even -> 1, odd -> 0, 110-cycle frame ----
        t3 = cyc;
        wr_en_p = 1'b1; wr_data_p = 8'h07;
        @(posedge clk); #1;
        wr_en_p = 1'b0;
        wait_until(t3 + 115);
        check("par_e_start", txd_pe_l[t3 + 2], 0);
        check("par_e_d0", txd_pe_l[t3 + 12], 1);
        check("par_e_d7", txd_pe_l[t3 + 91], 0);
        check("par_e_bit_first", txd_pe_l[t3 + 92], 1);
        check("par_e_bit_last", txd_pe_l[t3 + 101], 1);
        check("par_e_stop", txd_pe_l[t3 + 102], 1);
        check("par_o_bit_first", txd_po_l[t3 + 92], 0);
        check("par_o_bit_last", txd_po_l[t3 + 101], 0);
        check("par_o_stop", txd_po_l[t3 + 102], 1);
        check("par_e_no_early_done", done_pe_l[t3 + 101], 0);
        check("par_e_done_110", done_pe_l[t3 + 111], 1);
        check("par_o_done_110", done_po_l[t3 + 111], 1);

        // ---- overflow with DEPTH=4 while a frame is in flight ----
        t4 = cyc;
        write_a(8'h3C);
        wait_until(t4 + 5);
        foreach (ovf_tab[i]) begin
            wr_en_a = 1'b1; wr_data_a = ovf_tab[i].data;
            @(negedge clk);
            check($sformatf("ovf_full_w%0d", i), full_a, ovf_tab[i].full);
            check($sformatf("ovf_level_w%0d", i), level_a, ovf_tab[i].level);
            check($sformatf("ovf_pulse_w%0d", i), ovf_a, ovf_tab[i].ovf);
            @(posedge clk); #1;
        end
        wr_en_a = 1'b0;
        @(negedge clk);
        check("ovf_level_after", level_a, 4);
        check("ovf_full_after", full_a, 1);
        check("ovf_idle_pulse", ovf_a, 0);
        @(posedge clk); #1;

        // ---- full FIFO: write and pop in the same stop-end cycle ----
        wait_until(t4 + 101);
        wr_en_a = 1'b1; wr_data_a = 8'h99;
        @(negedge clk);
        check("wp_done", done_a, 1);
        check("wp_full", full_a, 1);
        check("wp_no_ovf", ovf_a, 0);
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        @(negedge clk);
        check("wp_level", level_a, 4);
        @(posedge clk); #1;
        n = 0;
        for (int c = t4; c <= t4 + 101; c++) if (ovf_l[c] === 1'b1) n++;
        check("ovf_pulse_count", n, 2);

        // ---- reset mid-DATA with 3 bytes queued (frame 0x22, D2 = 0) ----
        wait_until(t4 + 232);
        @(negedge clk);
        check("mid_level", level_a, 3);
        check("mid_busy", busy_a, 1);
        check("mid_txd_d2", txd_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ar_txd", txd_a, 1);
        check("ar_busy", busy_a, 0);
        check("ar_level", level_a, 0);
        check("ar_empty", empty_a, 1);
        check("ar_done", done_a, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        r = cyc;
        wait_until(r + 40);
        n = 0;
        for (int c = r; c < r + 40; c++) if (txd_l[c] !== 1'b1 || busy_l[c] !== 1'b0) n++;
        check("post_rst_idle", n, 0);
        t5 = cyc;
        write_a(8'h5A);
        wait_until(t5 + 3);
        check("post_rst_txd_t1", txd_l[t5 + 1], 1);
        check("post_rst_txd_t2", txd_l[t5 + 2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Self-contained, FIFO-buffered UART transmitter; the transmit-side counterpart of the oversampling UART receiver.
- Accepts bytes on a write strobe, queues them and serialises them LSB-first as 8-data-bit frames with an optional parity bit and 1 stop bit.
- Has its own integer baud divider, so it runs directly on the system clock with no external txclk.
- Feeds the board txd pin for response and echo traffic.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = (CLK_HZ + BAUD/2)/BAUD; DIV must be ≥ 4.
- DEPTH, 16, FIFO entries; must be a power of 2, ≥ 2.
- PARITY_EN, 0, 1 inserts a parity bit after D7.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd (used only when PARITY_EN=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; one byte per asserted cycle.
- wr_data  in  8  byte to queue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  1-cycle pulse when a write is dropped.
- txd  out  1  serial output, idle high.
- busy  out  1  high from the start bit through the end of the stop bit.
- done  out  1  1-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: txd=1, busy=0, done=0, overflow=0, empty=1, full=0, level=0.
  - FIFO pointers and the baud counter clear. FSM goes to IDLE.
  - A frame in flight is aborted immediately, with no partial stop bit.
- FIFO writes:
  - A write with full=0 is accepted.
  - A write with full=1 is accepted only if a pop occurs in the same cycle; otherwise it is dropped and overflow pulses.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH. level is registered and reflects accepted writes and pops on the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1. If empty=0, pop the head into the shift register and go to START; the baud counter loads DIV-1.
- Bit timing: the baud counter decrements every clk. A bit ends in the cycle the counter equals 0; it then reloads DIV-1. Every bit lasts exactly DIV cycles.
- START: txd=0 for one bit, then go to DATA with bit index 0.
- DATA: txd = shift[0]. At each bit end, shift right and increment the index. After index 7: go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: txd = XOR of the 8 data bits, XOR PARITY_ODD.
- STOP: txd=1 for one bit. In the final cycle of the stop bit, done=1.
  - If the FIFO is non-empty in that cycle: pop and go to START, so the next start bit follows with zero idle gap.
  - Otherwise go to IDLE.
- Latency: a write in cycle T into an empty FIFO while IDLE:
  - entry visible at T+1 (empty=0);
  - pop at T+1;
  - txd falls at T+2.
  - Frame length is (10+PARITY_EN)*DIV cycles.
- busy=1 from the cycle txd first goes low until the cycle after done. During back-to-back frames busy stays 1 continuously.
- wr_data is sampled only on an accepted write. Queued bytes are never modified by later writes.
- txd is driven from a register, so it is glitch-free.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - a function baud_div(clk_hz, baud) implementing the rounding rule;
  - the constants UART_DATA_BITS=8 and UART_IDLE=1'b1.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; same clk/reset) holds the storage, pointers, level, full and empty. The top block contains the FSM, baud counter, shift register and parity logic.

Test Plan (CLK_HZ=1000000, BAUD=100000, so DIV=10, unless stated):
- Single byte 0x55, PARITY_EN=0, write at T:
  - txd falls at T+2;
  - bit sequence is 0,1,0,1,0,1,0,1,0,1 with each bit held 10 cycles;
  - done pulses at T+101;
  - busy falls at T+102.
- Write 0xA3, 0x00, 0xFF in consecutive cycles:
  - three frames back-to-back with no idle cycle between stop and start;
  - exactly 3 done pulses, 100 cycles apart;
  - a receiver model recovers A3, 00, FF.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07: parity bit is 1 and the frame is 110 cycles. With PARITY_ODD=1, the same byte gives parity bit 0.
- Overflow, DEPTH=4, while a frame is transmitting (no pop):
  - write 6 bytes;
  - full asserts after the 4th accepted byte;
  - overflow pulses exactly twice;
  - level=4.
- Full FIFO with write and pop in the same cycle (at a stop-bit end): the write is accepted, level stays 4, and there is no overflow.
- reset driven low mid-DATA with 3 bytes queued:
  - txd=1 and busy=0 within the same cycle;
  - level=0;
  - after release, txd stays 1 until a new write arrives.
